r88_fetch: RTL and testbench
============================

Name: r88_fetch

Overview:
Instruction fetch sequencer, directly upstream of r88_regblock's PC path and downstream of its regAddr output. It selects PC as the register address source and reads opcode and operand bytes from memory through a ready handshake. It pulses incPC once per accepted byte and presents a complete instruction (opcode plus 0-2 operands) to the execute sequencer through a valid/ready handshake. Instruction length comes from the external decoder, which looks at the captured opcode.

Parameters:
SETTLE_CYCLES, 2, cycles waited after an incPC pulse before regAddr is trusted (the regblock PC and the regAddr buffer are both registered)
MEM_TIMEOUT, 255, maximum cycles memRd is held without memReady before the fetch aborts; 0 disables the timeout

Ports:
sysClock  in  1  system clock, rising edge
sysResetN  in  1  asynchronous active-low reset
fetchEn  in  1  permission to start or continue fetching
flush  in  1  synchronous abort (branch or interrupt); highest priority
regAddr  in  16  address bus from r88_regblock
regAddrSel  out  2  constant 2'd2 (PC)
incPC  out  1  one-cycle pulse per accepted byte
memAddr  out  16  memory read address
memRd  out  1  memory read request
memReady  in  1  memory data valid this cycle
memData  in  8  memory read data
opLen  in  2  decoder length for the opcode output: 0 or 1 means 1 byte, 2 means 2 bytes, 3 means 3 bytes
opcode  out  8  captured opcode byte
operandLo  out  8  first operand byte
operandHi  out  8  second operand byte
instPC  out  16  address of the opcode byte
instValid  out  1  instruction complete
instReady  in  1  execute accepts the instruction
busy  out  1  state is not IDLE
busErr  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, sysResetN=0): state=IDLE. All outputs are 0 except regAddrSel=2'd2. Counters are cleared.
- States: IDLE, SETTLE, REQ, DONE.
- IDLE: if fetchEn, go to SETTLE with byteIdx=0.
- SETTLE: count SETTLE_CYCLES cycles, then go to REQ. The first fetch after reset or flush also settles.
- REQ:
  - On entry, register memAddr<=regAddr and memRd=1.
  - memAddr and memRd stay stable until memReady.
  - On memReady, store memData into slot byteIdx (0=opcode, 1=operandLo, 2=operandHi), drop memRd, and pulse incPC for exactly one cycle.
  - When byteIdx=0, also capture instPC<=memAddr.
- Length decision:
  - opLen is sampled only after the opcode register is updated, never in the same cycle as the capture.
  - Effective length: 0 or 1 means 1, otherwise the opLen value.
  - If byteIdx+1 equals the effective length, go to DONE.
  - Otherwise increment byteIdx and go to SETTLE.
- Unused operand fields read 8'h00. They are cleared when a new opcode is captured.
- DONE:
  - instValid=1; opcode, operands and instPC are held stable.
  - On instValid and instReady, instValid drops next cycle.
  - Then go to SETTLE if fetchEn, else IDLE.
  - fetchEn deasserting in DONE does not drop instValid.
- fetchEn deasserting mid-instruction does not abort. The current instruction completes and the block idles afterwards.
- Timeout (MEM_TIMEOUT>0):
  - The wait counter counts REQ cycles with memRd high.
  - When it reaches MEM_TIMEOUT, pulse busErr, drop memRd, go to IDLE.
  - No incPC on timeout; partial bytes are discarded.
- flush:
  - Next state is IDLE and instValid=0 next cycle; memRd drops.
  - If memReady coincides with flush, the byte is discarded and incPC is not pulsed.
  - flush overrides instReady acceptance in the same cycle.
- Throughput: at least SETTLE_CYCLES+1 cycles per byte with zero-wait memory.
- System rule: the execute sequencer keeps regRead and regWrite low while busy=1 and instValid=0, because r88_regblock ignores incPC during register access.

Decomposition:
- Shared package r88_pkg holds:
  - fetch state encoding (2 bits)
  - regAddrSel constants (REGADDR_BC=0, DD=1, PC=2, SP=3)
  - the opLen decode constants
- Sub-module r88_fetch_timer: settle and timeout down-counter with load, enable and zero flag, instantiated twice.

Test Plan:
- 1-byte opcode: PC=0x1000, zero-wait memory returns 0x3A, opLen=1 → a single incPC pulse, instValid with opcode=3A, operands 00, instPC=1000.
- 3-byte instruction: bytes 0x4C,0x34,0x12, opLen=3, instReady held low for 5 cycles → three incPC pulses; fields stay stable until accept; instPC = the start address.
- Wait states: memReady delayed 4 cycles per byte → memRd and memAddr stable throughout; exactly one incPC per byte.
- Timeout: MEM_TIMEOUT=8, memReady never → busErr pulses on cycle 8 of memRd; no incPC; IDLE, then refetch from the same PC.
- Flush coincident with memReady on operand byte 2 → no incPC, instValid stays 0, state=IDLE next cycle.
- Async reset mid-REQ → memRd, incPC and instValid are 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/r88_pkg.sv
// Shared definitions for the r88 fetch path: state encoding, register
// address select codes and opcode length decode.
package r88_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_REQ    = 2'd2,
    ST_DONE   = 2'd3
  } fetch_state_t;

  localparam logic [1:0] REGADDR_BC = 2'd0;
  localparam logic [1:0] REGADDR_DD = 2'd1;
  localparam logic [1:0] REGADDR_PC = 2'd2;
  localparam logic [1:0] REGADDR_SP = 2'd3;

  localparam logic [1:0] OPLEN_NONE = 2'd0;
  localparam logic [1:0] OPLEN_1B   = 2'd1;
  localparam logic [1:0] OPLEN_2B   = 2'd2;
  localparam logic [1:0] OPLEN_3B   = 2'd3;

  localparam int TIMER_W = 16;

  // A decoder length of zero still means the opcode byte itself.
  function automatic logic [1:0] eff_len(input logic [1:0] op_len);
    return (op_len == OPLEN_NONE) ? OPLEN_1B : op_len;
  endfunction

endpackage

// File: rtl/r88_fetch_timer.sv
// Loadable down-counter with a zero flag; used for both the settle delay
// and the memory-wait timeout.
module r88_fetch_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the counter parks at zero instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/r88_fetch.sv
// Instruction fetch sequencer: reads opcode and operand bytes at PC, pulses
// incPC per accepted byte and hands a complete instruction to execute.
module r88_fetch
  import r88_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic        sysClock,
  input  logic        sysResetN,
  input  logic        fetchEn,
  input  logic        flush,
  input  logic [15:0] regAddr,
  output logic [1:0]  regAddrSel,
  output logic        incPC,
  output logic [15:0] memAddr,
  output logic        memRd,
  input  logic        memReady,
  input  logic [7:0]  memData,
  input  logic [1:0]  opLen,
  output logic [7:0]  opcode,
  output logic [7:0]  operandLo,
  output logic [7:0]  operandHi,
  output logic [15:0] instPC,
  output logic        instValid,
  input  logic        instReady,
  output logic        busy,
  output logic        busErr
);

  localparam logic [TIMER_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 0) ? TIMER_W'(SETTLE_CYCLES - 1) : '0;
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD =
    (MEM_TIMEOUT > 0) ? TIMER_W'(MEM_TIMEOUT - 1) : '0;
  localparam bit TIMEOUT_ON = (MEM_TIMEOUT > 0);

  fetch_state_t state;
  fetch_state_t next_state;

  logic [1:0] byte_idx;
  logic       decide;
  logic       capture;
  logic       timeout_hit;
  logic       len_done;
  logic       settle_load;
  logic       settle_zero;
  logic       req_entry;
  logic       wait_zero;

  // decide marks the cycle after a capture, so opLen reflects the new opcode.
  assign capture     = memRd && memReady && !flush;
  assign timeout_hit = TIMEOUT_ON && memRd && !memReady && wait_zero;
  assign len_done    = decide && ((byte_idx + 2'd1) == eff_len(opLen));
  assign settle_load = (next_state == ST_SETTLE) && (state != ST_SETTLE);
  assign req_entry   = (state == ST_SETTLE) && (next_state == ST_REQ);

  r88_fetch_timer #(.WIDTH(TIMER_W)) u_settle_timer (
    .clk      (sysClock),
    .rst_n    (sysResetN),
    .load     (settle_load),
    .load_val (SETTLE_LOAD),
    .en       (state == ST_SETTLE),
    .zero     (settle_zero)
  );

  r88_fetch_timer #(.WIDTH(TIMER_W)) u_wait_timer (
    .clk      (sysClock),
    .rst_n    (sysResetN),
    .load     (req_entry),
    .load_val (TIMEOUT_LOAD),
    .en       (memRd),
    .zero     (wait_zero)
  );

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (fetchEn) next_state = ST_SETTLE;
        ST_SETTLE: if (settle_zero) next_state = ST_REQ;
        ST_REQ: begin
          if (decide) begin
            next_state = len_done ? ST_DONE : ST_SETTLE;
          end else if (timeout_hit) begin
            next_state = ST_IDLE;
          end
        end
        ST_DONE: begin
          if (instReady) next_state = fetchEn ? ST_SETTLE : ST_IDLE;
        end
        default:   next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    regAddrSel = REGADDR_PC;
    busy       = (state != ST_IDLE);
    instValid  = (state == ST_DONE);
    memRd      = (state == ST_REQ) && !decide;
  end

  // Byte bookkeeping and single-cycle pulses; flush and timeout discard progress.
  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      byte_idx <= 2'd0;
      decide   <= 1'b0;
      incPC    <= 1'b0;
      busErr   <= 1'b0;
      memAddr  <= 16'h0000;
    end else begin
      decide <= capture;
      incPC  <= capture;
      busErr <= timeout_hit && !flush;
      if (req_entry) begin
        memAddr <= regAddr;
      end
      if (flush || timeout_hit || (state == ST_IDLE) || (state == ST_DONE)) begin
        byte_idx <= 2'd0;
      end else if (decide && !len_done) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      opcode    <= 8'h00;
      operandLo <= 8'h00;
      operandHi <= 8'h00;
      instPC    <= 16'h0000;
    end else if (capture) begin
      case (byte_idx)
        2'd0: begin
          opcode    <= memData;
          operandLo <= 8'h00;
          operandHi <= 8'h00;
          instPC    <= memAddr;
        end
        2'd1:    operandLo <= memData;
        2'd2:    operandHi <= memData;
        default: operandHi <= operandHi;
      endcase
    end
  end

endmodule

// File: tb/tb_r88_fetch.sv
// Directed bench for r88_fetch with a small PC/regAddr model, byte memory
// and an opcode-length decoder driven from the captured opcode.
module tb_r88_fetch;

  logic        sysClock  = 1'b0;
  logic        sysResetN = 1'b0;
  logic        fetchEn   = 1'b0;
  logic        flush     = 1'b0;
  logic [15:0] regAddr   = 16'h0000;
  logic [1:0]  regAddrSel;
  logic        incPC;
  logic [15:0] memAddr;
  logic        memRd;
  logic        memReady  = 1'b0;
  logic [7:0]  memData   = 8'h00;
  logic [1:0]  opLen;
  logic [7:0]  opcode;
  logic [7:0]  operandLo;
  logic [7:0]  operandHi;
  logic [15:0] instPC;
  logic        instValid;
  logic        instReady = 1'b0;
  logic        busy;
  logic        busErr;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] model_pc    = 16'h0000;
  logic        pc_load     = 1'b0;
  logic [15:0] pc_load_val = 16'h0000;

  r88_fetch #(.SETTLE_CYCLES(2), .MEM_TIMEOUT(8)) dut (
    .sysClock   (sysClock),
    .sysResetN  (sysResetN),
    .fetchEn    (fetchEn),
    .flush      (flush),
    .regAddr    (regAddr),
    .regAddrSel (regAddrSel),
    .incPC      (incPC),
    .memAddr    (memAddr),
    .memRd      (memRd),
    .memReady   (memReady),
    .memData    (memData),
    .opLen      (opLen),
    .opcode     (opcode),
    .operandLo  (operandLo),
    .operandHi  (operandHi),
    .instPC     (instPC),
    .instValid  (instValid),
    .instReady  (instReady),
    .busy       (busy),
    .busErr     (busErr)
  );

  always #5 sysClock = ~sysClock;

  function automatic logic [1:0] dec_len(input logic [7:0] op);
    case (op)
      8'h4C:   return 2'd3;
      8'h22:   return 2'd2;
      8'h3A:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  assign opLen = dec_len(opcode);

  // Regblock stand-in: PC register followed by a registered regAddr buffer.
  always @(posedge sysClock) begin
    if (pc_load) model_pc <= pc_load_val;
    else if (incPC) model_pc <= model_pc + 16'h0001;
    regAddr <= model_pc;
  end

  task automatic set_pc(input logic [15:0] a);
    @(negedge sysClock);
    pc_load = 1'b1;
    pc_load_val = a;
    @(negedge sysClock);
    pc_load = 1'b0;
    @(negedge sysClock);
  endtask

  // Memory responder: ready after wait_n stalled cycles; returns on instValid.
  task automatic run_fetch(input int wait_n, input int budget, output int inc_cnt,
                           output int rd_cycles, output bit addr_ok, output bit done);
    int rd_run;
    logic [15:0] addr0;
    inc_cnt = 0; rd_cycles = 0; addr_ok = 1'b1; done = 1'b0; rd_run = 0; addr0 = 16'h0000;
    for (int c = 0; c < budget; c++) begin
      @(negedge sysClock);
      if (incPC === 1'b1) inc_cnt++;
      if (instValid === 1'b1) begin
        memReady = 1'b0;
        done = 1'b1;
        break;
      end
      if (memRd === 1'b1) begin
        if (rd_run == 0) addr0 = memAddr;
        else if (memAddr !== addr0) addr_ok = 1'b0;
        rd_run++;
        rd_cycles++;
        if (rd_run > wait_n) begin
          memReady = 1'b1;
          memData = mem[memAddr];
        end else begin
          memReady = 1'b0;
          memData = 8'hEE;
        end
      end else begin
        rd_run = 0;
        memReady = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    sysResetN = 1'b0;
    #12;
    vectors++;
    if (regAddrSel !== 2'd2) begin miscompares++; $display("[TB] FAIL reset_regaddrsel: got %0d expected 2", regAddrSel); end
    vectors++;
    if ({memRd, incPC, instValid, busy, busErr} !== 5'b0) begin
      miscompares++; $display("[TB] FAIL reset_flags: got %b expected 00000", {memRd, incPC, instValid, busy, busErr});
    end
    vectors++;
    if ({opcode, operandLo, operandHi, instPC, memAddr} !== 56'h0) begin
      miscompares++; $display("[TB] FAIL reset_fields: got %h expected 0", {opcode, operandLo, operandHi, instPC, memAddr});
    end
    @(negedge sysClock);
    sysResetN = 1'b1;
  endtask

  task automatic test_one_byte;
    int inc, rd; bit aok, done;
    set_pc(16'h1000);
    fetchEn = 1'b1;
    run_fetch(0, 40, inc, rd, aok, done);
    vectors++;
    if (!done) begin miscompares++; $display("[TB] FAIL one_byte_done: got instValid %b expected 1 within budget", instValid); end
    vectors++;
    if (inc != 1) begin miscompares++; $display("[TB] FAIL one_byte_incpc: got %0d pulses expected 1", inc); end
    vectors++;
    if ({opcode, operandLo, operandHi} !== 24'h3A0000) begin
      miscompares++; $display("[TB] FAIL one_byte_fields: got %h expected 3a0000", {opcode, operandLo, operandHi});
    end
    vectors++;
    if (instPC !== 16'h1000) begin miscompares++; $display("[TB] FAIL one_byte_instpc: got %h expected 1000", instPC); end
    instReady = 1'b1;
    fetchEn = 1'b0;
    @(negedge sysClock);
    instReady = 1'b0;
    vectors++;
    if ({instValid, busy} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL one_byte_accept: got valid/busy %b expected 00", {instValid, busy});
    end
  endtask

  task automatic test_three_byte;
    int inc, rd; bit aok, done, hold_ok;
    set_pc(16'h2000);
    fetchEn = 1'b1;
    run_fetch(0, 80, inc, rd, aok, done);
    fetchEn = 1'b0;
    vectors++;
    if (!done) begin miscompares++; $display("[TB] FAIL three_byte_done: got instValid %b expected 1 within budget", instValid); end
    vectors++;
    if (inc != 3) begin miscompares++; $display("[TB] FAIL three_byte_incpc: got %0d pulses expected 3", inc); end
    vectors++;
    if ({opcode, operandLo, operandHi, instPC} !== 40'h4C3412_2000) begin
      miscompares++; $display("[TB] FAIL three_byte_fields: got %h expected 4c34122000", {opcode, operandLo, operandHi, instPC});
    end
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysClock);
      if ({instValid, opcode, operandLo, operandHi, instPC} !== {1'b1, 40'h4C3412_2000}) hold_ok = 1'b0;
    end
    vectors++;
    if (!hold_ok) begin
      miscompares++; $display("[TB] FAIL three_byte_hold: got %h expected 14c34122000", {instValid, opcode, operandLo, operandHi, instPC});
    end
    instReady = 1'b1;
    @(negedge sysClock);
    instReady = 1'b0;
    vectors++;
    if ({instValid, busy} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL three_byte_accept: got valid/busy %b expected 00", {instValid, busy});
    end
  endtask

  task automatic test_wait_states;
    int inc, rd; bit aok, done;
    set_pc(16'h2003);
    fetchEn = 1'b1;
    run_fetch(4, 100, inc, rd, aok, done);
    fetchEn = 1'b0;
    vectors++;
    if (!done) begin miscompares++; $display("[TB] FAIL wait_done: got instValid %b expected 1 within budget", instValid); end
    vectors++;
    if (inc != 2) begin miscompares++; $display("[TB] FAIL wait_incpc: got %0d pulses expected 2", inc); end
    vectors++;
    if (rd != 10) begin miscompares++; $display("[TB] FAIL wait_memrd_cycles: got %0d expected 10", rd); end
    vectors++;
    if (!aok) begin miscompares++; $display("[TB] FAIL wait_addr_stable: got unstable memAddr expected stable"); end
    vectors++;
    if ({opcode, operandLo, operandHi, instPC} !== 40'h225500_2003) begin
      miscompares++; $display("[TB] FAIL wait_fields: got %h expected 2255002003", {opcode, operandLo, operandHi, instPC});
    end
    instReady = 1'b1;
    @(negedge sysClock);
    instReady = 1'b0;
  endtask

  task automatic test_timeout;
    int inc, rd, inc2, rd2; bit seen, busy_at_err, aok, done;
    set_pc(16'h3000);
    fetchEn = 1'b1;
    inc = 0; rd = 0; seen = 1'b0; busy_at_err = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge sysClock);
      memReady = 1'b0;
      if (incPC === 1'b1) inc++;
      if (busErr === 1'b1) begin
        seen = 1'b1;
        busy_at_err = busy;
        break;
      end
      if (memRd === 1'b1) rd++;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("[TB] FAIL timeout_buserr: got no busErr expected pulse"); end
    vectors++;
    if (rd != 8) begin miscompares++; $display("[TB] FAIL timeout_memrd_cycles: got %0d expected 8", rd); end
    vectors++;
    if (inc != 0) begin miscompares++; $display("[TB] FAIL timeout_incpc: got %0d pulses expected 0", inc); end
    vectors++;
    if (busy_at_err !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_idle: got busy %b expected 0", busy_at_err); end
    @(negedge sysClock);
    vectors++;
    if (busErr !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_pulse_width: got busErr %b expected 0", busErr); end
    run_fetch(0, 40, inc2, rd2, aok, done);
    fetchEn = 1'b0;
    vectors++;
    if (!done || {opcode, instPC} !== 24'h3A_3000 || inc2 != 1) begin
      miscompares++; $display("[TB] FAIL timeout_refetch: got done %b op/pc %h inc %0d expected 1 3a3000 1", done, {opcode, instPC}, inc2);
    end
    instReady = 1'b1;
    @(negedge sysClock);
    instReady = 1'b0;
  endtask

  task automatic test_flush;
    int inc; bit hit;
    set_pc(16'h4000);
    fetchEn = 1'b1;
    inc = 0; hit = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge sysClock);
      if (incPC === 1'b1) inc++;
      if (memRd === 1'b1) begin
        memReady = 1'b1;
        memData = mem[memAddr];
        if (inc == 2) begin
          flush = 1'b1;
          hit = 1'b1;
          break;
        end
      end else begin
        memReady = 1'b0;
      end
    end
    vectors++;
    if (!hit) begin miscompares++; $display("[TB] FAIL flush_reach: got %0d bytes expected third byte request", inc); end
    @(negedge sysClock);
    memReady = 1'b0;
    flush = 1'b0;
    fetchEn = 1'b0;
    vectors++;
    if ({incPC, instValid, busy, memRd} !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL flush_state: got inc/valid/busy/rd %b expected 0000", {incPC, instValid, busy, memRd});
    end
    vectors++;
    if (operandHi !== 8'h00) begin miscompares++; $display("[TB] FAIL flush_discard: got operandHi %h expected 00", operandHi); end
    @(negedge sysClock);
    vectors++;
    if ({incPC, instValid} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL flush_after: got inc/valid %b expected 00", {incPC, instValid});
    end
  endtask

  task automatic test_async_reset;
    bit got;
    set_pc(16'h5000);
    fetchEn = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge sysClock);
      memReady = 1'b0;
      if (memRd === 1'b1) begin got = 1'b1; break; end
    end
    vectors++;
    if (!got) begin miscompares++; $display("[TB] FAIL async_reach_req: got no memRd expected request"); end
    #2;
    sysResetN = 1'b0;
    #1;
    vectors++;
    if ({memRd, incPC, instValid, busy} !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL async_reset_flags: got %b expected 0000", {memRd, incPC, instValid, busy});
    end
    vectors++;
    if ({opcode, memAddr, regAddrSel} !== {8'h00, 16'h0000, 2'd2}) begin
      miscompares++; $display("[TB] FAIL async_reset_fields: got %h expected 00000002", {opcode, memAddr, regAddrSel});
    end
    fetchEn = 1'b0;
    @(negedge sysClock);
    sysResetN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem[16'h1000] = 8'h3A;
    mem[16'h2000] = 8'h4C; mem[16'h2001] = 8'h34; mem[16'h2002] = 8'h12;
    mem[16'h2003] = 8'h22; mem[16'h2004] = 8'h55;
    mem[16'h3000] = 8'h3A;
    mem[16'h4000] = 8'h4C; mem[16'h4001] = 8'h11; mem[16'h4002] = 8'h22;
    mem[16'h5000] = 8'h3A;
    test_reset;
    test_one_byte;
    test_three_byte;
    test_wait_states;
    test_timeout;
    test_flush;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
